// File: rtl/mult_div_seq.sv
// Iterative multiply/divide engine with architectural HI/LO registers.
// Performs one shift-add (multiply) or restoring shift-subtract (divide) step per clock.
// Signed operations run on operand magnitudes; a fix-up cycle negates the results afterwards.
module mult_div_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             stall_o,
    output logic             div_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFix,
        StDone
    } state_e;

    localparam logic [CNT_W-1:0] LastIter = CNT_W'(WIDTH - 1);

    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q;
    // Multiply: {partial product high, multiplier shifting out}.
    // Divide:   {partial remainder, dividend shifting out / quotient shifting in}.
    logic [2*WIDTH-1:0]   acc_q;
    // Multiplicand magnitude (multiply) or divisor magnitude (divide).
    logic [WIDTH-1:0]     opb_q;
    logic                 is_div_q;
    // neg_lo_q: negate product / quotient; neg_hi_q: negate remainder.
    logic                 neg_lo_q;
    logic                 neg_hi_q;
    logic                 div0_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 div_zero_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;

    logic                 accepting;
    logic                 in_is_div;
    logic                 in_neg1;
    logic                 in_neg2;
    logic [WIDTH-1:0]     in_mag1;
    logic [WIDTH-1:0]     in_mag2;

    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH:0]       div_diff;
    logic [2*WIDTH-1:0]   div_next;

    logic [2*WIDTH-1:0]   prod_neg;
    logic [WIDTH-1:0]     fix_hi;
    logic [WIDTH-1:0]     fix_lo;

    // Decode the incoming request: operand magnitudes and their signs (signed ops only).
    always_comb begin
        accepting = (state_q == StIdle) || (state_q == StDone);
        in_is_div = op_i[1];
        in_neg1   = op_i[0] & src1_i[WIDTH-1];
        in_neg2   = op_i[0] & src2_i[WIDTH-1];
        in_mag1   = in_neg1 ? ('0 - src1_i) : src1_i;
        in_mag2   = in_neg2 ? ('0 - src2_i) : src2_i;
    end

    // One iteration of each algorithm, selected by is_div_q in the state register block.
    always_comb begin
        // Shift-add: add multiplicand into the upper half when the current multiplier bit is set,
        // then shift the whole accumulator right, keeping the carry.
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
        if (acc_q[0]) begin
            mul_next = {mul_sum, acc_q[WIDTH-1:1]};
        end else begin
            mul_next = {1'b0, acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1:1]};
        end

        // Restoring divide: shift next dividend bit into the remainder and try the subtract.
        // Bit WIDTH of the difference is the borrow (remainder smaller than divisor).
        rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff = rem_sh - {1'b0, opb_q};
        if (div_diff[WIDTH]) begin
            div_next = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end
    end

    // Sign fix-up of the raw magnitude result, producing the values written to HI/LO.
    always_comb begin
        prod_neg = '0 - acc_q;
        fix_hi   = acc_q[2*WIDTH-1:WIDTH];
        fix_lo   = acc_q[WIDTH-1:0];
        if (div0_q) begin
            // Upper half holds the untouched dividend for a zero divisor.
            fix_lo = '1;
        end else if (!is_div_q) begin
            if (neg_lo_q) begin
                fix_hi = prod_neg[2*WIDTH-1:WIDTH];
                fix_lo = prod_neg[WIDTH-1:0];
            end
        end else begin
            if (neg_lo_q) begin
                fix_lo = '0 - acc_q[WIDTH-1:0];
            end
            if (neg_hi_q) begin
                fix_hi = '0 - acc_q[2*WIDTH-1:WIDTH];
            end
        end
    end

    // Control FSM, iteration datapath and registered outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            acc_q      <= '0;
            opb_q      <= '0;
            is_div_q   <= 1'b0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            div0_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (start_i) begin
                        is_div_q   <= in_is_div;
                        div_zero_q <= 1'b0;
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        neg_lo_q   <= in_neg1 ^ in_neg2;
                        neg_hi_q   <= in_neg1;
                        if (in_is_div && (src2_i == '0)) begin
                            // No iterations: park the raw dividend for HI and go straight to FIX.
                            div0_q  <= 1'b1;
                            acc_q   <= {src1_i, {WIDTH{1'b0}}};
                            opb_q   <= '0;
                            state_q <= StFix;
                        end else begin
                            div0_q  <= 1'b0;
                            acc_q   <= {{WIDTH{1'b0}}, in_is_div ? in_mag1 : in_mag2};
                            opb_q   <= in_is_div ? in_mag2 : in_mag1;
                            state_q <= StRun;
                        end
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    acc_q <= is_div_q ? div_next : mul_next;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LastIter) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    hi_q       <= fix_hi;
                    lo_q       <= fix_lo;
                    div_zero_q <= div0_q;
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= StDone;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign stall_o    = busy_q | (start_i & accepting);
    assign div_zero_o = div_zero_q;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;

endmodule
